// File: rtl/led_mmio_arbiter.sv
// ---------------------------------------------------------------------------
// led_mmio_arbiter
//
// Shares the single MMIO write port feeding the LED register between two bus
// masters (CPU store path = master 0, debug/DMA engine = master 1).
// Round-robin arbitration with a valid/ready handshake per requester; the
// granted write is registered and presented on mmio_out_addr/mmio_out for
// exactly one cycle, otherwise both outputs read zero.
//
// Optional feature (compile-time macro LED_HEARTBEAT_EN):
//   a heartbeat engine that writes led_shadow ^ 8'h01 to LED_ADDR after
//   HB_PERIOD cycles without an LED write. Without the macro the output only
//   ever carries requester writes and HB_PERIOD has no effect.
//
// Parameters:
//   HB_PERIOD     idle cycles between heartbeat writes (2 .. 2^24-1)
//   LED_ADDR      address treated as the LED register
//
// Ports:
//   clock         in   sole clock, all state on the rising edge
//   reset_n       in   synchronous active-low reset
//   req0_valid    in   master 0 write request
//   req0_ready    out  master 0 write accepted this cycle (combinational)
//   req0_addr     in   master 0 write address
//   req0_data     in   master 0 write data
//   req1_valid    in   master 1 write request
//   req1_ready    out  master 1 write accepted this cycle (combinational)
//   req1_addr     in   master 1 write address
//   req1_data     in   master 1 write data
//   mmio_out_addr out  registered write address, 16'h0000 when idle
//   mmio_out      out  registered write data, 8'h00 when idle
//   led_shadow    out  last data written to LED_ADDR (reset 8'h2A)
// ---------------------------------------------------------------------------
module led_mmio_arbiter #(
    parameter logic [23:0] HB_PERIOD = 24'd13_500_000,
    parameter logic [15:0] LED_ADDR  = 16'hF000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_addr,
    input  logic [7:0]  req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_addr,
    input  logic [7:0]  req1_data,
    output logic [15:0] mmio_out_addr,
    output logic [7:0]  mmio_out,
    output logic [7:0]  led_shadow
);

    // Value the LED register holds out of reset (6'b101010 zero-extended).
    localparam logic [7:0] LED_RESET_VALUE = 8'h2A;

    // Master that won the most recent transfer. Reset to 1 so that master 0
    // wins the first contention.
    logic        last_grant_reg;

    logic [15:0] out_addr_reg;
    logic [7:0]  out_data_reg;
    logic [7:0]  shadow_reg;

    logic        grant0;
    logic        grant1;
    logic        hb_fire;

    logic [15:0] out_addr_next;
    logic [7:0]  out_data_next;
    logic        out_write_next;
    logic        led_write_next;

    // ------------------------------------------------------------------
    // Arbitration. A lone valid always wins; under contention the master
    // that did not win last time goes. Nothing is accepted during reset.
    // ------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n) begin
            grant0 = req0_valid && (!req1_valid || last_grant_reg);
            grant1 = req1_valid && (!req0_valid || !last_grant_reg);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // ------------------------------------------------------------------
    // Next output write: requester transfers first, heartbeat only when
    // neither master is asking (hb_fire already includes that condition).
    // ------------------------------------------------------------------
    always_comb begin
        out_addr_next  = 16'h0000;
        out_data_next  = 8'h00;
        out_write_next = 1'b0;
        if (grant0) begin
            out_addr_next  = req0_addr;
            out_data_next  = req0_data;
            out_write_next = 1'b1;
        end else if (grant1) begin
            out_addr_next  = req1_addr;
            out_data_next  = req1_data;
            out_write_next = 1'b1;
        end else if (hb_fire) begin
            out_addr_next  = LED_ADDR;
            out_data_next  = shadow_reg ^ 8'h01;
            out_write_next = 1'b1;
        end
    end

    // The enable qualifies the compare so an idle cycle (address 0) never
    // looks like an LED write, even if LED_ADDR were parameterised to 0.
    assign led_write_next = out_write_next && (out_addr_next == LED_ADDR);

    // ------------------------------------------------------------------
    // Output register, shadow and round-robin state.
    // The shadow is loaded on the same edge the write is registered, so it
    // always agrees with the most recent LED write seen on the output.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_grant_reg <= 1'b1;
            out_addr_reg   <= 16'h0000;
            out_data_reg   <= 8'h00;
            shadow_reg     <= LED_RESET_VALUE;
        end else begin
            out_addr_reg <= out_addr_next;
            out_data_reg <= out_data_next;
            if (grant0) begin
                last_grant_reg <= 1'b0;
            end else if (grant1) begin
                last_grant_reg <= 1'b1;
            end
            if (led_write_next) begin
                shadow_reg <= out_data_next;
            end
        end
    end

    assign mmio_out_addr = out_addr_reg;
    assign mmio_out      = out_data_reg;
    assign led_shadow    = shadow_reg;

`ifdef LED_HEARTBEAT_EN
    // ------------------------------------------------------------------
    // Heartbeat engine.
    //
    // The counter restarts when it reaches HB_PERIOD-1 (raising hb_pending)
    // and whenever a master writes LED_ADDR. The heartbeat's own write does
    // not restart it again: the restart already happened when pending was
    // raised, which makes back-to-back heartbeats exactly HB_PERIOD cycles
    // apart on an otherwise idle bus.
    //
    // A master write to LED_ADDR also cancels a pending heartbeat so the
    // user's value is not immediately overwritten by a toggle.
    // ------------------------------------------------------------------
    logic [23:0] hb_count_reg;
    logic        hb_pending_reg;
    logic        req_led_write;

    assign req_led_write = led_write_next && (grant0 || grant1);
    assign hb_fire       = hb_pending_reg && !req0_valid && !req1_valid;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hb_count_reg   <= 24'd0;
            hb_pending_reg <= 1'b0;
        end else if (req_led_write) begin
            hb_count_reg   <= 24'd0;
            hb_pending_reg <= 1'b0;
        end else begin
            // Clear on emission first; a terminal count in the same cycle
            // then re-arms pending for the next period.
            if (hb_fire) begin
                hb_pending_reg <= 1'b0;
            end
            if (hb_count_reg == HB_PERIOD - 24'd1) begin
                hb_count_reg   <= 24'd0;
                hb_pending_reg <= 1'b1;
            end else begin
                hb_count_reg <= hb_count_reg + 24'd1;
            end
        end
    end
`else
    // No heartbeat engine: the output carries requester writes only.
    logic unused_hb_period;

    assign hb_fire          = 1'b0;
    assign unused_hb_period = ^HB_PERIOD;
`endif

endmodule

// File: tb/tb_led_mmio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_led_mmio_arbiter
//
// Directed-vector bench for led_mmio_arbiter. Inputs are driven 1 time unit
// after the rising edge; combinational readies are checked 1 unit after that
// and registered outputs 1 unit after each rising edge. Heartbeat scenarios
// are compiled in only when LED_HEARTBEAT_EN is defined (HB_PERIOD = 8).
// ---------------------------------------------------------------------------
module tb_led_mmio_arbiter;

    localparam logic [15:0] LED = 16'hF000;

    logic        clock;
    logic        reset_n;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_addr;
    logic [7:0]  req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_addr;
    logic [7:0]  req1_data;
    logic [15:0] mmio_out_addr;
    logic [7:0]  mmio_out;
    logic [7:0]  led_shadow;

    int vectors_applied;
    int miscompares;

    led_mmio_arbiter #(
        .HB_PERIOD (24'd8),
        .LED_ADDR  (LED)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_addr     (req0_addr),
        .req0_data     (req0_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_addr     (req1_addr),
        .req1_data     (req1_data),
        .mmio_out_addr (mmio_out_addr),
        .mmio_out      (mmio_out),
        .led_shadow    (led_shadow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] a, input logic [7:0] d);
        check_vec({tag, ".addr"}, {16'h0, mmio_out_addr}, {16'h0, a});
        check_vec({tag, ".data"}, {24'h0, mmio_out}, {24'h0, d});
    endtask

    task automatic check_ready(input string tag, input logic r0, input logic r1);
        #1;
        check_vec({tag, ".rdy0"}, {31'h0, req0_ready}, {31'h0, r0});
        check_vec({tag, ".rdy1"}, {31'h0, req1_ready}, {31'h0, r1});
    endtask

    // Two reset edges, then release 1 unit after the second edge.
    task automatic do_reset();
        reset_n    = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        vectors_applied = 0;
        miscompares     = 0;
        reset_n    = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = 16'h0;
        req0_data  = 8'h0;
        req1_addr  = 16'h0;
        req1_data  = 8'h0;

        // ---------------- reset state + single request ----------------
        tick();
        tick();
        check_out("reset_out", 16'h0000, 8'h00);
        check_vec("reset_shadow", {24'h0, led_shadow}, 32'h2A);
        reset_n    = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = LED;
        req0_data  = 8'h15;
        check_ready("single", 1'b1, 1'b0);
        tick();
        req0_valid = 1'b0;
        check_out("single_out", LED, 8'h15);
        tick();
        check_out("single_idle", 16'h0000, 8'h00);
        check_vec("single_shadow", {24'h0, led_shadow}, 32'h15);

        // ---------------- contention: grants 0,1,0,1 ----------------
        do_reset();
        req0_valid = 1'b1; req0_addr = 16'h1000; req0_data = 8'hA0;
        req1_valid = 1'b1; req1_addr = 16'h1001; req1_data = 8'hB1;
        for (int i = 0; i < 4; i++) begin
            check_ready($sformatf("cont%0d", i), (i % 2) == 0, (i % 2) == 1);
            tick();
            if ((i % 2) == 0) check_out($sformatf("cont%0d_out", i), 16'h1000, 8'hA0);
            else              check_out($sformatf("cont%0d_out", i), 16'h1001, 8'hB1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check_out("cont_idle", 16'h0000, 8'h00);

        // ---------------- non-LED address ----------------
        do_reset();
        req1_valid = 1'b1; req1_addr = 16'h8000; req1_data = 8'hAA;
        check_ready("nonled", 1'b0, 1'b1);
        tick();
        req1_valid = 1'b0;
        check_out("nonled_out", 16'h8000, 8'hAA);
        check_vec("nonled_shadow", {24'h0, led_shadow}, 32'h2A);
        tick();
        check_out("nonled_idle", 16'h0000, 8'h00);

        // ---------------- reset mid-stream ----------------
        do_reset();
        req0_valid = 1'b1; req0_addr = LED;      req0_data = 8'h55;
        req1_valid = 1'b1; req1_addr = 16'h2000; req1_data = 8'h66;
        check_ready("mid_pre", 1'b1, 1'b0);
        tick();
        check_out("mid_write", LED, 8'h55);
        check_vec("mid_shadow55", {24'h0, led_shadow}, 32'h55);
        reset_n = 1'b0;
        check_ready("mid_rst", 1'b0, 1'b0);
        tick();
        check_out("mid_cleared", 16'h0000, 8'h00);
        check_vec("mid_shadow", {24'h0, led_shadow}, 32'h2A);
        reset_n = 1'b1;
        check_ready("mid_rel", 1'b1, 1'b0);
        tick();
        check_out("mid_first", LED, 8'h55);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check_out("mid_idle", 16'h0000, 8'h00);

`ifdef LED_HEARTBEAT_EN
        // ---------------- heartbeat on idle bus ----------------
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_out($sformatf("hb_wait%0d", i), 16'h0000, 8'h00);
        end
        tick();
        check_out("hb_first", LED, 8'h2B);
        check_vec("hb_first_shadow", {24'h0, led_shadow}, 32'h2B);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_out($sformatf("hb_gap%0d", i), 16'h0000, 8'h00);
        end
        tick();
        check_out("hb_second", LED, 8'h2A);

        // ---------------- heartbeat deferred by a request ----------------
        for (int i = 1; i <= 7; i++) tick();
        check_out("hb_armed", 16'h0000, 8'h00);
        req0_valid = 1'b1; req0_addr = 16'h8000; req0_data = 8'h33;
        for (int i = 0; i < 3; i++) begin
            check_ready($sformatf("defer%0d", i), 1'b1, 1'b0);
            tick();
            if (i == 2) req0_valid = 1'b0;
            check_out($sformatf("defer%0d_out", i), 16'h8000, 8'h33);
        end
        tick();
        check_out("defer_hb", LED, 8'h2B);
        tick();
        check_out("defer_idle", 16'h0000, 8'h00);

        // ---------------- user LED write cancels pending ----------------
        do_reset();
        for (int i = 1; i <= 8; i++) tick();
        req1_valid = 1'b1; req1_addr = LED; req1_data = 8'h77;
        tick();
        req1_valid = 1'b0;
        check_out("cancel_user", LED, 8'h77);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_out($sformatf("cancel_idle%0d", i), 16'h0000, 8'h00);
        end
        check_vec("cancel_shadow", {24'h0, led_shadow}, 32'h77);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
